// File: rtl/i2c_slave_regs.sv
// I2C target with a 7-bit address and eight 8-bit registers.
// The register pointer auto-increments on writes and reads.
// Host logic gets a write strobe and a combinational read side port.
module i2c_slave_regs #(
   parameter logic [6:0] I2C_ADDR = 7'h50
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic       busy_o,
   output logic       wr_stb_o,
   output logic [2:0] wr_idx_o,
   output logic [7:0] wr_data_o,
   input  logic [2:0] reg_sel_i,
   output logic [7:0] reg_dout_o
);

   localparam int unsigned DW   = 8;
   localparam int unsigned IW   = 3;
   localparam int unsigned NREG = 8;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, WPTR, WDATA, WACK, RDATA, RACK, WAIT_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      scl_sync_q, sda_sync_q;
   logic            scl_hist_q, sda_hist_q;
   logic [DW-1:0]   shift_q, shift_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            sda_oe_q, sda_oe_d;
   logic            busy_q, busy_d;
   logic            wr_stb_q, wr_stb_d;
   logic [IW-1:0]   wr_idx_q, wr_idx_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [DW-1:0]   regs_q [NREG];

   logic            scl_s, sda_s;
   logic            scl_rise_c, scl_fall_c, start_c, stop_c, last_bit_c;
   logic [DW-1:0]   byte_c, rd_byte_c;

   // Two-flop synchronizers plus one history flop; reset to the idle-high bus level
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign scl_s      = scl_sync_q[1];
   assign sda_s      = sda_sync_q[1];
   assign scl_rise_c = scl_s & ~scl_hist_q;
   assign scl_fall_c = ~scl_s & scl_hist_q;
   assign start_c    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_c     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
   assign last_bit_c = (bit_cnt_q == 3'd7);
   assign byte_c     = {shift_q[DW-2:0], sda_s};
   assign rd_byte_c  = regs_q[ptr_q];

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; bus conditions override bit processing
   always_comb begin
      state_d = state_q;
      if (stop_c) begin
         state_d = IDLE;
      end else if (start_c) begin
         state_d = ADDR;
      end else begin
         case (state_q)
            ADDR: if (scl_rise_c && last_bit_c)
                     state_d = (byte_c[7:1] == I2C_ADDR) ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: if (scl_fall_c && bit_cnt_q == 3'd1)
                     state_d = shift_q[0] ? RDATA : WPTR;
            WPTR, WDATA: if (scl_rise_c && last_bit_c) state_d = WACK;
            WACK: if (scl_fall_c && bit_cnt_q == 3'd1) state_d = WDATA;
            RDATA: if (scl_fall_c && last_bit_c) state_d = RACK;
            RACK: begin
               if (scl_rise_c && sda_s)                      state_d = WAIT_STOP;
               else if (scl_fall_c && bit_cnt_q == 3'd1)     state_d = RDATA;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      if (stop_c) begin
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = 3'd0;
      end else if (start_c) begin
         sda_oe_d  = 1'b0;
         bit_cnt_d = 3'd0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise_c) begin
               shift_d   = byte_c;
               bit_cnt_d = last_bit_c ? 3'd0 : bit_cnt_q + 3'd1;
               if (last_bit_c) busy_d = (byte_c[7:1] == I2C_ADDR);
            end
            // ACK slot: pull low from the 8th to the 9th SCL falling edge
            ADDR_ACK, WACK: if (scl_fall_c) begin
               if (bit_cnt_q == 3'd0) begin
                  sda_oe_d  = 1'b1;
                  bit_cnt_d = 3'd1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd0;
                  if (state_q == ADDR_ACK && shift_q[0]) begin
                     shift_d  = rd_byte_c;
                     sda_oe_d = ~rd_byte_c[7];
                     ptr_d    = ptr_q + 3'd1;
                  end
               end
            end
            WPTR: if (scl_rise_c) begin
               shift_d   = byte_c;
               bit_cnt_d = last_bit_c ? 3'd0 : bit_cnt_q + 3'd1;
               if (last_bit_c) ptr_d = byte_c[IW-1:0];
            end
            WDATA: if (scl_rise_c) begin
               shift_d   = byte_c;
               bit_cnt_d = last_bit_c ? 3'd0 : bit_cnt_q + 3'd1;
               if (last_bit_c) begin
                  wr_stb_d  = 1'b1;
                  wr_idx_d  = ptr_q;
                  wr_data_d = byte_c;
                  ptr_d     = ptr_q + 3'd1;
               end
            end
            RDATA: if (scl_fall_c) begin
               if (last_bit_c) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd0;
               end else begin
                  shift_d   = {shift_q[DW-2:0], 1'b0};
                  sda_oe_d  = ~shift_q[DW-2];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            RACK: begin
               if (scl_rise_c) begin
                  if (sda_s) busy_d    = 1'b0;
                  else       bit_cnt_d = 3'd1;
               end else if (scl_fall_c && bit_cnt_q == 3'd1) begin
                  shift_d   = rd_byte_c;
                  sda_oe_d  = ~rd_byte_c[7];
                  ptr_d     = ptr_q + 3'd1;
                  bit_cnt_d = 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Register bank commits the strobed write one cycle after the strobe
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_stb_q) begin
         regs_q[wr_idx_q] <= wr_data_q;
      end
   end

   assign sda_oe_o   = sda_oe_q;
   assign busy_o     = busy_q;
   assign wr_stb_o   = wr_stb_q;
   assign wr_idx_o   = wr_idx_q;
   assign wr_data_o  = wr_data_q;
   assign reg_dout_o = regs_q[reg_sel_i];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-bank model.
module tb_i2c_slave_regs;

   localparam int unsigned Q = 5;   // clocks per quarter SCL period

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_oe_o, busy_o, wr_stb_o;
   logic [2:0] wr_idx_o;
   logic [7:0] wr_data_o;
   logic [2:0] reg_sel;
   logic [7:0] reg_dout_o;

   int n_cmp = 0;
   int n_err = 0;
   int model_regs [8];
   int model_ptr;
   logic [10:0] strb_q [$];
   int oe_cnt, busy_cnt;

   typedef struct {
      logic [7:0] ptr;
      int         n;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [2:0] sel;
      logic [7:0] exp_sel;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t tbl [5];

   assign sda_bus = sda_m & ~sda_oe_o;

   i2c_slave_regs dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .scl_i      (scl_m),
      .sda_i      (sda_bus),
      .sda_oe_o   (sda_oe_o),
      .busy_o     (busy_o),
      .wr_stb_o   (wr_stb_o),
      .wr_idx_o   (wr_idx_o),
      .wr_data_o  (wr_data_o),
      .reg_sel_i  (reg_sel),
      .reg_dout_o (reg_dout_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(negedge wb_clk_i) begin
      if (wr_stb_o) strb_q.push_back({wr_idx_o, wr_data_o});
      if (sda_oe_o) oe_cnt++;
      if (busy_o)   busy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge wb_clk_i);
   endtask

   task automatic bit_io(input logic b, output logic s);
      sda_m = b;  wq();
      scl_m = 1'b1; wq();
      s = sda_bus; wq();
      scl_m = 1'b0; wq();
   endtask

   // Works both from idle and as a repeated START with SCL low
   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
      bit_io(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, s);
         b[i] = s;
      end
      bit_io(nack, s);
   endtask

   task automatic chk_regs();
      for (int i = 0; i < 8; i++) begin
         reg_sel = 3'(i);
         #1;
         chk($sformatf("reg_dout[%0d]", i), int'(reg_dout_o), model_regs[i]);
      end
   endtask

   // Write transaction: address, pointer byte, n data bytes, STOP
   task automatic wr_txn(input logic [7:0] pb, input int n, input logic [7:0] dat [4]);
      logic       ack;
      logic [10:0] e;
      int exp_idx [$];
      int exp_dat [$];
      strb_q.delete();
      i2c_start();
      write_byte(8'hA0, ack);
      chk("wr_addr_ack", int'(ack), 0);
      chk("busy_after_addr", int'(busy_o), 1);
      write_byte(pb, ack);
      chk("ptr_ack", int'(ack), 0);
      model_ptr = int'(pb) % 8;
      for (int i = 0; i < n; i++) begin
         write_byte(dat[i], ack);
         chk("data_ack", int'(ack), 0);
         exp_idx.push_back(model_ptr);
         exp_dat.push_back(int'(dat[i]));
         model_regs[model_ptr] = int'(dat[i]);
         model_ptr = (model_ptr + 1) % 8;
      end
      i2c_stop();
      wq();
      chk("strobe_count", strb_q.size(), n);
      for (int i = 0; i < n && i < strb_q.size(); i++) begin
         e = strb_q[i];
         chk("strobe_idx", int'(e[10:8]), exp_idx[i]);
         chk("strobe_data", int'(e[7:0]), exp_dat[i]);
      end
      chk("busy_after_stop", int'(busy_o), 0);
   endtask

   // Read transaction: optional pointer set + repeated START, m bytes, NACK on last
   task automatic rd_txn(input logic set_ptr, input logic [7:0] pb, input int m,
                         output logic [7:0] last);
      logic       ack;
      logic [7:0] b;
      last = 8'h00;
      i2c_start();
      if (set_ptr) begin
         write_byte(8'hA0, ack);
         chk("rd_waddr_ack", int'(ack), 0);
         write_byte(pb, ack);
         chk("rd_ptr_ack", int'(ack), 0);
         model_ptr = int'(pb) % 8;
         i2c_start();
      end
      write_byte(8'hA1, ack);
      chk("rd_addr_ack", int'(ack), 0);
      for (int i = 0; i < m; i++) begin
         read_byte(i == m - 1, b);
         chk("rd_data", int'(b), model_regs[model_ptr]);
         model_ptr = (model_ptr + 1) % 8;
         last = b;
      end
      chk("oe_after_nack", int'(sda_oe_o), 0);
      chk("busy_after_nack", int'(busy_o), 0);
      i2c_stop();
      wq();
   endtask

   initial begin
      logic [7:0] dat [4];
      logic [7:0] rd;
      logic       ack, s;

      tbl[0] = '{ptr: 8'h01, n: 1, d0: 8'h77, d1: 8'h00, sel: 3'd1, exp_sel: 8'h77, exp_rd: 8'h00};
      tbl[1] = '{ptr: 8'h02, n: 2, d0: 8'h11, d1: 8'h22, sel: 3'd3, exp_sel: 8'h22, exp_rd: 8'h00};
      tbl[2] = '{ptr: 8'h07, n: 2, d0: 8'hAA, d1: 8'hBB, sel: 3'd7, exp_sel: 8'hAA, exp_rd: 8'h77};
      tbl[3] = '{ptr: 8'hF8, n: 0, d0: 8'h00, d1: 8'h00, sel: 3'd0, exp_sel: 8'hBB, exp_rd: 8'hBB};
      tbl[4] = '{ptr: 8'h05, n: 2, d0: 8'h5A, d1: 8'hC3, sel: 3'd6, exp_sel: 8'hC3, exp_rd: 8'hAA};

      for (int i = 0; i < 8; i++) model_regs[i] = 0;
      model_ptr = 0;
      wb_rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1; reg_sel = 3'd0;
      oe_cnt = 0; busy_cnt = 0;
      repeat (4) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);

      // Reset state
      chk("rst_sda_oe", int'(sda_oe_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_wr_stb", int'(wr_stb_o), 0);
      chk("rst_wr_idx", int'(wr_idx_o), 0);
      chk("rst_wr_data", int'(wr_data_o), 0);
      chk_regs();

      // Directed table: write with pointer, then read back from where the pointer ended
      for (int t = 0; t < 5; t++) begin
         dat[0] = tbl[t].d0; dat[1] = tbl[t].d1; dat[2] = 8'h00; dat[3] = 8'h00;
         wr_txn(tbl[t].ptr, tbl[t].n, dat);
         reg_sel = tbl[t].sel;
         #1;
         chk("tbl_sel", int'(reg_dout_o), int'(tbl[t].exp_sel));
         rd_txn(1'b0, 8'h00, 1, rd);
         chk("tbl_rd", int'(rd), int'(tbl[t].exp_rd));
      end

      // Read via repeated START: regs 5/6 hold 0x5A/0xC3
      rd_txn(1'b1, 8'h05, 2, rd);
      chk("rstart_last", int'(rd), 8'hC3);

      // Address mismatch: never drive SDA, no strobe, never busy
      strb_q.delete(); oe_cnt = 0; busy_cnt = 0;
      i2c_start();
      write_byte(8'hA2, ack); chk("mis_addr_nack", int'(ack), 1);
      write_byte(8'h01, ack); chk("mis_b1_nack", int'(ack), 1);
      write_byte(8'h99, ack); chk("mis_b2_nack", int'(ack), 1);
      i2c_stop(); wq();
      chk("mis_oe_cycles", oe_cnt, 0);
      chk("mis_busy_cycles", busy_cnt, 0);
      chk("mis_strobes", strb_q.size(), 0);

      // Abort: STOP after 4 data bits discards the byte
      strb_q.delete();
      i2c_start();
      write_byte(8'hA0, ack); chk("abort_addr_ack", int'(ack), 0);
      write_byte(8'h03, ack); chk("abort_ptr_ack", int'(ack), 0);
      for (int i = 0; i < 4; i++) bit_io(1'b1, s);
      i2c_stop(); wq();
      chk("abort_strobes", strb_q.size(), 0);
      chk("abort_oe", int'(sda_oe_o), 0);
      chk("abort_busy", int'(busy_o), 0);
      chk_regs();

      // Randomized write/read traffic against the register model
      for (int it = 0; it < 16; it++) begin
         int n, m;
         logic [7:0] pb;
         n  = int'($urandom_range(0, 3));
         pb = 8'($urandom);
         for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
         wr_txn(pb, n, dat);
         m  = int'($urandom_range(1, 3));
         pb = 8'($urandom);
         rd_txn(1'($urandom), pb, m, rd);
         if (it % 4 == 3) chk_regs();
      end

      // Reset while the target drives a 0 data bit
      dat[0] = 8'h3C; dat[1] = 8'h00; dat[2] = 8'h00; dat[3] = 8'h00;
      wr_txn(8'h04, 1, dat);
      i2c_start();
      write_byte(8'hA0, ack); chk("rr_waddr_ack", int'(ack), 0);
      write_byte(8'h04, ack); chk("rr_ptr_ack", int'(ack), 0);
      i2c_start();
      write_byte(8'hA1, ack); chk("rr_addr_ack", int'(ack), 0);
      chk("rr_oe_driving", int'(sda_oe_o), 1);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      chk("rr_oe_after_rst", int'(sda_oe_o), 0);
      chk("rr_busy_after_rst", int'(busy_o), 0);
      wb_rst_i = 1'b0;
      for (int i = 0; i < 8; i++) model_regs[i] = 0;
      model_ptr = 0;
      chk_regs();
      scl_m = 1'b1; sda_m = 1'b1;
      wq(); wq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
